sev_seg_reader: RTL and testbench

SEV_SEG_READER -- requirements
Module: sev_seg_reader

---
 rtl/sev_seg_pkg.sv | 20 ++
 rtl/seg_decode.sv | 24 ++
 rtl/sev_seg_reader.sv | 165 ++++++++++++++++
 tb/tb_sev_seg_reader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment bus reader: hex glyph table, blank pattern, FSM states.
// Used by seg_decode and sev_seg_reader.
package sev_seg_pkg;

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_HOLD   = 1'b1
   } state_e;

   // Active-high patterns, bit 6 = g ... bit 0 = a, indexed by hex value.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [6:0] SEG_BLANK      = 7'h00;
   // Idle level of the active-low pins.
   localparam logic [6:0] SEG_PINS_BLANK = 7'h7F;

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment glyph decoder: active-high pattern in, hex nibble plus
// valid/blank flags out.
module seg_decode
   import sev_seg_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic [3:0] o_nibble,
   output logic       o_valid,
   output logic       o_blank
);

   always_comb begin
      o_nibble = 4'h0;
      o_valid  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i_pattern == SEG_HEX[i]) begin
            o_nibble = 4'(i);
            o_valid  = 1'b1;
         end
      end
      o_blank = (i_pattern == SEG_BLANK);
   end

endmodule

// File: rtl/sev_seg_reader.sv
// Reads a two-digit multiplexed seven-segment bus back into a byte.
// Optional macro SEV_SEG_READER_CHANGE_ONLY_EN: suppress o_valid for a pair equal to o_byte.
//
// state  | meaning
// SETTLE | bus value changed recently; counting unchanged cycles toward capture
// HOLD   | current value already captured; wait for the next change
module sev_seg_reader
   import sev_seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [6:0] i_segments,
   input  logic       i_cathode,
   output logic [7:0] o_byte,
   output logic       o_valid,
   output logic       o_error
);

   localparam int unsigned           CNT_W    = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]       seg_meta_q, seg_sync_q;
   logic             cath_meta_q, cath_sync_q;
   logic [7:0]       smp_prev_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       nib0_q, nib0_d, nib1_q, nib1_d;
   logic             got0_q, got0_d, got1_q, got1_d;
   logic [7:0]       byte_q, byte_d;
   logic             valid_q, valid_d, error_q, error_d;
   logic             changed, capture;
   logic [6:0]       seg_ah;
   logic [3:0]       dec_nibble;
   logic             dec_valid, dec_blank;
`ifdef SEV_SEG_READER_CHANGE_ONLY_EN
   logic             first_q, first_d;
`endif

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         seg_meta_q  <= SEG_PINS_BLANK;
         seg_sync_q  <= SEG_PINS_BLANK;
         cath_meta_q <= 1'b1;
         cath_sync_q <= 1'b1;
         smp_prev_q  <= {1'b1, SEG_PINS_BLANK};
      end else begin
         seg_meta_q  <= i_segments;
         seg_sync_q  <= seg_meta_q;
         cath_meta_q <= i_cathode;
         cath_sync_q <= cath_meta_q;
         smp_prev_q  <= {cath_sync_q, seg_sync_q};
      end
   end

   assign changed = ({cath_sync_q, seg_sync_q} != smp_prev_q);
   assign seg_ah  = ~seg_sync_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (changed) begin
         state_d = ST_SETTLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == CNT_LAST) begin
                  capture = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_HOLD: ;
         endcase
      end
   end

   seg_decode u_decode (
      .i_pattern (seg_ah),
      .o_nibble  (dec_nibble),
      .o_valid   (dec_valid),
      .o_blank   (dec_blank)
   );

   always_comb begin
      nib0_d  = nib0_q;
      nib1_d  = nib1_q;
      got0_d  = got0_q;
      got1_d  = got1_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      error_d = 1'b0;
`ifdef SEV_SEG_READER_CHANGE_ONLY_EN
      first_d = first_q;
`endif
      if (capture) begin
         if (dec_valid) begin
            if (cath_sync_q) begin
               nib0_d = dec_nibble;
               got0_d = 1'b1;
            end else begin
               nib1_d = dec_nibble;
               got1_d = 1'b1;
            end
         end else if (!dec_blank) begin
            error_d = 1'b1;
         end
      end
      // Pair completes in the same cycle as the second digit's capture.
      if (got0_d && got1_d) begin
         got0_d = 1'b0;
         got1_d = 1'b0;
`ifdef SEV_SEG_READER_CHANGE_ONLY_EN
         if (first_q || ({nib1_d, nib0_d} != byte_q)) begin
            byte_d  = {nib1_d, nib0_d};
            valid_d = 1'b1;
         end
         first_d = 1'b0;
`else
         byte_d  = {nib1_d, nib0_d};
         valid_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_SETTLE;
         cnt_q   <= '0;
         nib0_q  <= 4'h0;
         nib1_q  <= 4'h0;
         got0_q  <= 1'b0;
         got1_q  <= 1'b0;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nib0_q  <= nib0_d;
         nib1_q  <= nib1_d;
         got0_q  <= got0_d;
         got1_q  <= got1_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

`ifdef SEV_SEG_READER_CHANGE_ONLY_EN
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) first_q <= 1'b1;
      else            first_q <= first_d;
   end
`endif

   assign o_byte  = byte_q;
   assign o_valid = valid_q;
   assign o_error = error_q;

endmodule

// File: tb/tb_sev_seg_reader.sv
// Directed bench for sev_seg_reader with STABLE_CYCLES=4; expected values hand-computed.
module tb_sev_seg_reader;

   localparam int S = 4;
`ifdef SEV_SEG_READER_CHANGE_ONLY_EN
   localparam int EXP_REPEAT = 1;
`else
   localparam int EXP_REPEAT = 2;
`endif

   logic       i_clock = 1'b0;
   logic       i_reset_n;
   logic [6:0] i_segments;
   logic       i_cathode;
   logic [7:0] o_byte;
   logic       o_valid;
   logic       o_error;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         last_valid_cyc = 0;
   logic [7:0] last_byte = 8'h00;
   bit         both_seen = 1'b0;
   int         base_v, base_e, start_cyc;

   sev_seg_reader #(.STABLE_CYCLES(S)) dut (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_segments (i_segments),
      .i_cathode  (i_cathode),
      .o_byte     (o_byte),
      .o_valid    (o_valid),
      .o_error    (o_error)
   );

   always #5 i_clock = ~i_clock;

   always @(posedge i_clock) cyc++;

   always @(negedge i_clock) begin
      if (o_valid) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         last_byte = o_byte;
      end
      if (o_error) err_cnt++;
      if (o_valid && o_error) both_seen = 1'b1;
   end

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(negedge i_clock);
         #2;
      end
   endtask

   task automatic present(logic cath, logic [6:0] pat, int n);
      i_cathode  = cath;
      i_segments = ~pat;
      start_cyc  = cyc;
      step(n);
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      step(2);
      i_reset_n = 1'b1;
      step(1);
   endtask

   initial begin
      i_reset_n  = 1'b0;
      i_segments = 7'h7F;
      i_cathode  = 1'b1;
      step(3);
      check("reset_byte",  32'(o_byte),  32'h00);
      check("reset_valid", 32'(o_valid), 32'h0);
      check("reset_error", 32'(o_error), 32'h0);
      i_reset_n = 1'b1;
      step(2);

      // digit0 = 5, digit1 = A
      base_v = valid_cnt; base_e = err_cnt;
      present(1'b1, 7'h6D, 10);
      present(1'b0, 7'h77, 10);
      check("a5_latency_ok", 32'((last_valid_cyc - start_cyc) <= S + 4 && last_valid_cyc > start_cyc), 32'h1);
      step(2);
      check("a5_valid_count", 32'(valid_cnt - base_v), 32'd1);
      check("a5_strobe_byte", 32'(last_byte), 32'hA5);
      check("a5_o_byte",      32'(o_byte),    32'hA5);
      check("a5_no_error",    32'(err_cnt - base_e), 32'd0);

      // glitching every 3 cycles must never capture
      base_v = valid_cnt; base_e = err_cnt;
      for (int i = 0; i < 8; i++)
         present(1'b1, (i % 2 == 1) ? 7'h06 : 7'h5B, 3);
      check("glitch_no_valid", 32'(valid_cnt - base_v), 32'd0);
      check("glitch_no_error", 32'(err_cnt - base_e),   32'd0);
      present(1'b1, 7'h00, 10);
      present(1'b0, 7'h4F, 10);
      check("glitch_no_digit0", 32'(valid_cnt - base_v), 32'd0);
      do_reset();

      // invalid pattern then blank
      base_v = valid_cnt; base_e = err_cnt;
      present(1'b1, 7'h01, 10);
      check("inv_one_error", 32'(err_cnt - base_e),   32'd1);
      check("inv_no_valid",  32'(valid_cnt - base_v), 32'd0);
      check("inv_byte_kept", 32'(o_byte), 32'h00);
      present(1'b1, 7'h00, 10);
      check("blank_no_error", 32'(err_cnt - base_e), 32'd1);
      do_reset();

      // digit0 3 then 7, then digit1 2
      base_v = valid_cnt;
      present(1'b1, 7'h4F, 10);
      present(1'b1, 7'h07, 10);
      present(1'b0, 7'h5B, 10);
      step(2);
      check("newer_valid_count", 32'(valid_cnt - base_v), 32'd1);
      check("newer_byte",        32'(o_byte), 32'h27);
      do_reset();

      // reset mid-pair discards captured digit0
      present(1'b1, 7'h6D, 10);
      i_cathode  = 1'b0;
      i_segments = ~7'h5B;
      i_reset_n  = 1'b0;
      step(2);
      i_reset_n = 1'b1;
      base_v = valid_cnt;
      step(12);
      check("rst_pair_no_valid", 32'(valid_cnt - base_v), 32'd0);
      check("rst_pair_byte",     32'(o_byte), 32'h00);
      present(1'b1, 7'h6D, 10);
      check("rst_fresh_valid", 32'(valid_cnt - base_v), 32'd1);
      check("rst_fresh_byte",  32'(o_byte), 32'h25);
      do_reset();

      // same pair 3C twice
      base_v = valid_cnt;
      present(1'b1, 7'h39, 10);
      present(1'b0, 7'h4F, 10);
      present(1'b1, 7'h39, 10);
      present(1'b0, 7'h4F, 10);
      step(2);
      check("repeat_valid_count", 32'(valid_cnt - base_v), 32'(EXP_REPEAT));
      check("repeat_byte",        32'(o_byte), 32'h3C);

      check("valid_error_exclusive", 32'(both_seen), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
